// File: rtl/rc_sar_adc.sv
//------------------------------------------------------------------------------
// Module   : rc_sar_adc
// Brief    : Successive-approximation ADC digitizing the RC filter's signed
//            fixed-point output into an unsigned code with valid/ready output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rc_sar_adc #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 12,
  parameter int NBITS    = 8,
  parameter int VREF_RAW = 1 << FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] v_samp,
  input  logic             start,
  output logic             busy,
  output logic             code_valid,
  output logic [NBITS-1:0] code,
  input  logic             code_ready,
  output logic             overrun
);

  localparam int c_IDXW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int c_DW   = WIDTH + NBITS;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_CONVERT = 2'd1;
  localparam logic [1:0] c_HOLD    = 2'd2;

  localparam logic [c_DW-1:0]   c_VREF = c_DW'(VREF_RAW);
  localparam logic [NBITS-1:0]  c_MSB  = NBITS'(1) << (NBITS - 1);
  localparam logic [c_IDXW-1:0] c_TOP  = c_IDXW'(NBITS - 1);

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_hold;
  logic [NBITS-1:0]  r_trial;
  logic [NBITS-1:0]  r_result;
  logic [c_IDXW-1:0] r_bit_idx;

  logic [c_DW-1:0]   w_dac;
  logic              w_ge;
  logic [NBITS-1:0]  w_res;
  logic [NBITS-1:0]  w_next_trial;

  // Full-width product before the shift so large trials never truncate.
  assign w_dac = ({{WIDTH{1'b0}}, r_trial} * c_VREF) >> NBITS;

  // Sign-extended hold against zero-extended DAC: negative holds always lose.
  assign w_ge = $signed({{(NBITS + 1){r_hold[WIDTH-1]}}, r_hold}) >=
                $signed({1'b0, w_dac});

  assign w_res        = r_result | (NBITS'(w_ge) << r_bit_idx);
  assign w_next_trial = w_res | (NBITS'(1) << (r_bit_idx - c_IDXW'(1)));

  assign busy = (r_state != c_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_hold     <= '0;
      r_trial    <= '0;
      r_result   <= '0;
      r_bit_idx  <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start && (r_state != c_IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_hold    <= v_samp;
            r_trial   <= c_MSB;
            r_result  <= '0;
            r_bit_idx <= c_TOP;
            r_state   <= c_CONVERT;
          end
        end
        c_CONVERT: begin
          if (r_bit_idx == '0) begin
            code       <= w_res;
            code_valid <= 1'b1;
            r_state    <= c_HOLD;
          end else begin
            r_result  <= w_res;
            r_trial   <= w_next_trial;
            r_bit_idx <= r_bit_idx - c_IDXW'(1);
          end
        end
        c_HOLD: begin
          // code keeps its value after acceptance; only valid drops.
          if (code_ready) begin
            code_valid <= 1'b0;
            r_state    <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/rc_sar_adc.md
Name: rc_sar_adc

Overview:
- Successive-approximation ADC model that sits directly downstream of the discretized RC filter model. It digitizes the filter's fixed-point output voltage.
- On a start request it captures the input sample into an internal hold register, then resolves one bit per clock, MSB first.
- It presents an unsigned code to a consumer through a valid/ready handshake.
- It is used to close digital loops around the analog models and to give benches a quantized observation point.

Parameters:
- WIDTH, 16, bit width of the signed fixed-point input voltage.
- FRAC, 12, fractional bits of the input format (1.0 V = 2^FRAC raw).
- NBITS, 8, ADC resolution in bits.
- VREF_RAW, 4096, full-scale reference in input raw units (default 1.0 V).

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-low.
- v_samp  input  WIDTH  signed fixed-point voltage (filter output).
- start  input  1  conversion request, sampled on the rising edge.
- busy  output  1  high while state != IDLE.
- code_valid  output  1  conversion result available.
- code  output  NBITS  unsigned conversion result.
- code_ready  input  1  consumer accepts code.
- overrun  output  1  sticky flag: start asserted while busy.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, code_valid=0, code=0, overrun=0, internal hold/trial registers=0.
- State IDLE:
  - An edge with start=1 latches hold<=v_samp, trial<=1<<(NBITS-1), result<=0, bit_idx<=NBITS-1.
  - State then goes to CONVERT.
- State CONVERT, one bit per edge:
  - dac = (trial * VREF_RAW) >> NBITS, computed at WIDTH+NBITS bits with no truncation before the shift.
  - Compare is signed: bit_idx of result = (hold >= dac).
  - Next trial keeps the resolved bits, sets bit_idx-1, and clears lower bits.
  - On the edge resolving bit_idx==0: code<=final result, code_valid<=1, state<=HOLD.
- Latency: start accepted on edge 0; code_valid is high after edge NBITS (NBITS cycles).
- Input handling: v_samp changes after edge 0 have no effect on the result (sample-and-hold).
- State HOLD:
  - code and code_valid are held stable until an edge with code_ready=1.
  - On that edge: code_valid<=0, state<=IDLE. code keeps its last value.
- busy is 1 in CONVERT and HOLD, 0 in IDLE.
- start in CONVERT or HOLD is ignored and sets overrun<=1, which stays set until reset.
- Back-to-back conversions require one IDLE edge. start on the same edge as the HOLD->IDLE acceptance is ignored and counts as an overrun.
- Boundaries:
  - hold < 0 gives code 0.
  - hold >= VREF_RAW*(2^NBITS-1)/2^NBITS gives all ones (saturation, no wrap).
  - Results are floored, never rounded.
- Reset mid-conversion or mid-HOLD aborts immediately to the reset values. No partial code is ever exposed.
- code_ready while not in HOLD is ignored.

Test Plan:
- Defaults, v_samp=2048 (0.5 V), start pulse -> code_valid after 8 edges, code=128, busy high for 8 edges plus the HOLD duration.
- v_samp=2047 -> code=127. v_samp=1024 -> code=64. v_samp=16 -> code=1. v_samp=15 -> code=0.
- v_samp=-100 -> code=0. v_samp=5000 -> code=255. v_samp=4080 -> code=255. v_samp=4079 -> code=254.
- Drive from an RC model step (v_in 0->1.0 V): first filtered sample raw 390 -> code=24. Change v_samp mid-conversion -> code is still 24.
- Hold code_ready=0 for 5 cycles -> code and code_valid stable. Pulse start during HOLD -> ignored and overrun=1. Assert code_ready -> IDLE on the next edge.
- Assert rst low asynchronously at conversion bit 3 -> all outputs 0 immediately. Release rst, then start with v_samp=2048 -> code=128, overrun=0.
